// File: rtl/time_entry_buffer.sv
// time_entry_buffer
//
// Keypad-side entry stage of the microwave timer. Collects up to four BCD
// digits into an MM:SS buffer, shifting each new digit in from the right.
// On start the seconds field is clamped to at most 59 and a one-cycle
// active-low load strobe is issued to the downstream mod-10/mod-6 counter
// chain, whose parallel-load inputs are driven by the digit outputs.
//
// Ports:
//   clock          in   system clock, rising edge
//   clear          in   asynchronous active-high reset
//   keypad_valid   in   one-cycle strobe, keypad_digit valid this cycle
//   keypad_digit   in   [3:0] digit value, legal 0-9
//   start          in   one-cycle strobe, load buffer into counters
//   cancel         in   one-cycle strobe, discard current entry
//   timer_running  in   counter chain is counting; keys and start ignored
//   sec_units      out  [3:0] BCD seconds units
//   sec_tens       out  [3:0] BCD seconds tens (<= 5 while loadn = 0)
//   min_units      out  [3:0] BCD minutes units
//   min_tens       out  [3:0] BCD minutes tens
//   loadn          out  active-low load strobe, low for exactly one cycle
//   digit_count    out  [2:0] number of digits entered, 0-4
//   entry_error    out  one-cycle pulse after a rejected action
//
// Strobe semantics: keypad_valid, start and cancel are single-cycle
// requests with no back-pressure. Each is acted on at the rising edge where
// it is high, or dropped if it loses to a higher-priority request on that
// edge (cancel > start > key) or arrives while the block is in LOAD. There
// is no ready signal; a dropped or rejected request is not retried.

module time_entry_buffer (
    input  logic       clock,
    input  logic       clear,
    input  logic       keypad_valid,
    input  logic [3:0] keypad_digit,
    input  logic       start,
    input  logic       cancel,
    input  logic       timer_running,
    output logic [3:0] sec_units,
    output logic [3:0] sec_tens,
    output logic [3:0] min_units,
    output logic [3:0] min_tens,
    output logic       loadn,
    output logic [2:0] digit_count,
    output logic       entry_error
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Current FSM state; kept as a named register so checkers can bind to it.
    state_t state;

    logic key_legal;
    logic start_req;
    logic key_req;

    assign key_legal = (keypad_digit <= 4'd9) && (digit_count != 3'd4);
    // While the counters run, keys and start are ignored without an error.
    assign start_req = start && !timer_running;
    assign key_req   = keypad_valid && !timer_running;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state       <= EMPTY;
            sec_units   <= 4'd0;
            sec_tens    <= 4'd0;
            min_units   <= 4'd0;
            min_tens    <= 4'd0;
            loadn       <= 1'b1;
            digit_count <= 3'd0;
            entry_error <= 1'b0;
        end else begin
            entry_error <= 1'b0;
            case (state)
                LOAD: begin
                    // Load already committed: the counters capture on this
                    // edge, so every synchronous input is ignored here.
                    state       <= EMPTY;
                    loadn       <= 1'b1;
                    sec_units   <= 4'd0;
                    sec_tens    <= 4'd0;
                    min_units   <= 4'd0;
                    min_tens    <= 4'd0;
                    digit_count <= 3'd0;
                end
                default: begin
                    if (cancel) begin
                        state       <= EMPTY;
                        sec_units   <= 4'd0;
                        sec_tens    <= 4'd0;
                        min_units   <= 4'd0;
                        min_tens    <= 4'd0;
                        digit_count <= 3'd0;
                    end else if (start_req) begin
                        if (state == ENTRY) begin
                            state <= LOAD;
                            loadn <= 1'b0;
                            // Clamp the seconds field to 59; minutes are
                            // passed through unchanged (max entry 99:59).
                            if (sec_tens > 4'd5) begin
                                sec_tens  <= 4'd5;
                                sec_units <= 4'd9;
                            end
                        end else begin
                            entry_error <= 1'b1;
                        end
                    end else if (key_req) begin
                        if (key_legal) begin
                            state       <= ENTRY;
                            min_tens    <= min_units;
                            min_units   <= sec_tens;
                            sec_tens    <= sec_units;
                            sec_units   <= keypad_digit;
                            digit_count <= digit_count + 3'd1;
                        end else begin
                            entry_error <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_entry_buffer.sv
module tb_time_entry_buffer;

    logic       clock;
    logic       clear;
    logic       keypad_valid;
    logic [3:0] keypad_digit;
    logic       start;
    logic       cancel;
    logic       timer_running;
    logic [3:0] sec_units;
    logic [3:0] sec_tens;
    logic [3:0] min_units;
    logic [3:0] min_tens;
    logic       loadn;
    logic [2:0] digit_count;
    logic       entry_error;

    logic [15:0] digits;
    assign digits = {min_tens, min_units, sec_tens, sec_units};

    int n_compared;
    int n_mismatched;

    time_entry_buffer dut (
        .clock         (clock),
        .clear         (clear),
        .keypad_valid  (keypad_valid),
        .keypad_digit  (keypad_digit),
        .start         (start),
        .cancel        (cancel),
        .timer_running (timer_running),
        .sec_units     (sec_units),
        .sec_tens      (sec_tens),
        .min_units     (min_units),
        .min_tens      (min_tens),
        .loadn         (loadn),
        .digit_count   (digit_count),
        .entry_error   (entry_error)
    );

    // Clock and watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Checking task
    task automatic check(input string tag, input logic [15:0] observed,
                         input logic [15:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Driver tasks: outputs are sampled 1 time unit after each rising edge,
    // and inputs are changed at that same point.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        keypad_valid = 1'b1;
        keypad_digit = d;
        tick();
        keypad_valid = 1'b0;
        keypad_digit = 4'd0;
    endtask

    task automatic press_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic press_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    initial begin
        n_compared    = 0;
        n_mismatched  = 0;
        clear         = 1'b1;
        keypad_valid  = 1'b0;
        keypad_digit  = 4'd0;
        start         = 1'b0;
        cancel        = 1'b0;
        timer_running = 1'b0;
        #23;
        check("rst_digits", digits, 16'h0000);
        check("rst_loadn", 16'(loadn), 16'd1);
        check("rst_count", 16'(digit_count), 16'd0);
        check("rst_err", 16'(entry_error), 16'd0);
        clear = 1'b0;
        tick();

        // Keys 1,3,0 then start
        key(4'd1);
        check("k1_count", 16'(digit_count), 16'd1);
        check("k1_digits", digits, 16'h0001);
        key(4'd3);
        key(4'd0);
        check("k130_digits", digits, 16'h0130);
        check("k130_count", 16'(digit_count), 16'd3);
        check("k130_err", 16'(entry_error), 16'd0);
        press_start();
        check("ld1_loadn", 16'(loadn), 16'd0);
        check("ld1_digits", digits, 16'h0130);
        tick();
        check("ld1_after_loadn", 16'(loadn), 16'd1);
        check("ld1_after_digits", digits, 16'h0000);
        check("ld1_after_count", 16'(digit_count), 16'd0);

        // Clamp seconds: 99 -> 59
        key(4'd9);
        key(4'd9);
        press_start();
        check("clamp_loadn", 16'(loadn), 16'd0);
        check("clamp_digits", digits, 16'h0059);
        tick();
        check("clamp_after_loadn", 16'(loadn), 16'd1);

        // Minutes never clamped: 99:78 -> 99:59
        key(4'd9);
        key(4'd9);
        key(4'd7);
        key(4'd8);
        press_start();
        check("clamp4_digits", digits, 16'h9959);
        tick();

        // Seconds tens of exactly 5 are left alone: 12:57 stays
        key(4'd1);
        key(4'd2);
        key(4'd5);
        key(4'd7);
        press_start();
        check("noclamp_digits", digits, 16'h1257);
        tick();

        // Fifth key rejected
        key(4'd1);
        key(4'd2);
        key(4'd3);
        key(4'd4);
        check("k4_digits", digits, 16'h1234);
        check("k4_count", 16'(digit_count), 16'd4);
        key(4'd5);
        check("k5_err", 16'(entry_error), 16'd1);
        check("k5_digits", digits, 16'h1234);
        check("k5_count", 16'(digit_count), 16'd4);
        tick();
        check("k5_err_clear", 16'(entry_error), 16'd0);
        press_cancel();

        // Illegal digit 0xA in ENTRY
        key(4'd1);
        key(4'hA);
        check("kA_err", 16'(entry_error), 16'd1);
        check("kA_digits", digits, 16'h0001);
        check("kA_count", 16'(digit_count), 16'd1);
        tick();
        check("kA_err_clear", 16'(entry_error), 16'd0);
        press_cancel();

        // Start in EMPTY
        press_start();
        check("st_empty_err", 16'(entry_error), 16'd1);
        check("st_empty_loadn", 16'(loadn), 16'd1);
        tick();
        check("st_empty_err_clear", 16'(entry_error), 16'd0);

        // Key ignored while timer running
        timer_running = 1'b1;
        key(4'd7);
        check("run_count", 16'(digit_count), 16'd0);
        check("run_err", 16'(entry_error), 16'd0);
        timer_running = 1'b0;

        // Cancel after keys 4,2
        key(4'd4);
        key(4'd2);
        check("k42_digits", digits, 16'h0042);
        press_cancel();
        check("cancel_digits", digits, 16'h0000);
        check("cancel_count", 16'(digit_count), 16'd0);

        // Cancel honoured while timer running
        key(4'd6);
        timer_running = 1'b1;
        press_cancel();
        check("run_cancel_count", 16'(digit_count), 16'd0);
        timer_running = 1'b0;

        // Async clear mid-LOAD
        key(4'd2);
        key(4'd5);
        press_start();
        check("pre_clr_loadn", 16'(loadn), 16'd0);
        check("pre_clr_digits", digits, 16'h0025);
        #2;
        clear = 1'b1;
        #1;
        check("clr_loadn", 16'(loadn), 16'd1);
        check("clr_digits", digits, 16'h0000);
        check("clr_count", 16'(digit_count), 16'd0);
        #2;
        clear = 1'b0;
        tick();
        check("post_clr_loadn", 16'(loadn), 16'd1);

        // Start and key 8 together after keys 3,0
        key(4'd3);
        key(4'd0);
        start        = 1'b1;
        keypad_valid = 1'b1;
        keypad_digit = 4'd8;
        tick();
        start        = 1'b0;
        keypad_valid = 1'b0;
        check("stkey_loadn", 16'(loadn), 16'd0);
        check("stkey_digits", digits, 16'h0030);
        check("stkey_err", 16'(entry_error), 16'd0);
        tick();
        check("stkey_after_loadn", 16'(loadn), 16'd1);

        // Cancel and start together: entry discarded, no load
        key(4'd1);
        start  = 1'b1;
        cancel = 1'b1;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        check("cs_loadn", 16'(loadn), 16'd1);
        check("cs_count", 16'(digit_count), 16'd0);
        check("cs_err", 16'(entry_error), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/time_entry_buffer.md
# time_entry_buffer

Keypad-side entry stage of the microwave timer. It collects up to four BCD digits typed by the user into an MM:SS buffer, shifting each new digit in from the right. On start it clamps the seconds field to a legal value and issues a one-cycle active-low load strobe. That strobe drives the parallel-load inputs (`input_number`, `loadn`) of the downstream mod-10/mod-6 counter chain.

## Interface
Parameters: none.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `clear`  in  1  reset, asynchronous, active-high. Clears all state immediately.
- `keypad_valid`  in  1  one-cycle strobe; `keypad_digit` is valid this cycle.
- `keypad_digit`  in  4  digit value; legal range 0–9.
- `start`  in  1  one-cycle strobe requesting that the buffer be loaded into the counters.
- `cancel`  in  1  one-cycle strobe that discards the current entry.
- `timer_running`  in  1  high while the counter chain is counting (its `enable`).
- `sec_units`  out  4  BCD; drives the seconds-units counter `input_number`.
- `sec_tens`  out  4  BCD, 0–9 during entry; at most 5 while `loadn` is 0.
- `min_units`  out  4  BCD.
- `min_tens`  out  4  BCD.
- `loadn`  out  1  active-low load strobe to all four counters.
- `digit_count`  out  3  number of digits entered, 0–4.
- `entry_error`  out  1  one-cycle pulse on a rejected action.

## Operation
All outputs are registered.

Reset values:
- digit outputs 0
- `loadn` 1
- `digit_count` 0
- `entry_error` 0
- state EMPTY

States:
- EMPTY: `digit_count` = 0, all digits 0.
- ENTRY: `digit_count` is 1–4.
- LOAD: lasts exactly one cycle. `loadn` = 0; digits hold the clamped values.

Digit shift:
- On an accepted key: `min_tens`←`min_units`, `min_units`←`sec_tens`, `sec_tens`←`sec_units`, `sec_units`←`keypad_digit`.
- `digit_count` increments by 1.
- EMPTY→ENTRY on the first accepted key.

Key rejection (no shift; `entry_error` pulses):
- `keypad_digit` > 9.
- `digit_count` = 4 (a fifth digit).

Ignored inputs (no `entry_error`):
- While `timer_running` = 1: keys and `start` are ignored.
- `cancel` is still honoured while `timer_running` = 1.

Start:
- In ENTRY → LOAD. In the same edge, if `sec_tens` > 5, set `sec_tens`=5 and `sec_units`=9. This clamps the seconds field to 59.
- Minutes are never clamped; the maximum entry is 99:59.
- In EMPTY: stay in EMPTY and pulse `entry_error`.

LOAD → EMPTY unconditionally at the next edge:
- `loadn` returns to 1.
- All digits clear to 0.
- `digit_count` = 0.

Cancel:
- In EMPTY or ENTRY → EMPTY; digits and count cleared.

Priority per edge: `clear` (async) > `cancel` > `start` > key.
- `start` and a key together in ENTRY: the load occurs and the key is dropped, with no error.
- `cancel` and `start` together: the entry is discarded and no load occurs.

In LOAD, every synchronous input is ignored, including `cancel`; the load is already committed.

## Timing
- Key accepted at edge N → new digit and count visible from edge N.
- `start` sampled at edge N:
  - `loadn` = 0 and the clamped digits are visible for cycle N..N+1.
  - The counters capture at edge N+1.
  - `loadn` = 1 and digits = 0 from edge N+1.
- The digit outputs are stable for the whole cycle in which `loadn` = 0.
- `entry_error` is high for exactly one cycle: the cycle after the offending edge.
- `clear` asserted at any time, including mid-LOAD:
  - All outputs go to their reset values without waiting for a clock edge.
  - `loadn` goes high immediately.
- After `clear` deasserts, the first edge behaves as in EMPTY.

## Test plan
- Reset, then keys 1,3,0 → digits (`min_tens`..`sec_units`) = 0,1,3,0; `digit_count`=3. Then `start` → `loadn`=0 for exactly one cycle with 0,1,3,0, then `loadn`=1, digits 0, `digit_count` 0.
- Keys 9,9, then `start` → in the `loadn`=0 cycle, `sec_tens`=5 and `sec_units`=9; minutes 0.
- Keys 1,2,3,4, then 5 → the fifth key is rejected with a one-cycle `entry_error`; digits stay 1,2,3,4. Separately, key 0xA in ENTRY → `entry_error` pulse, no shift.
- `start` in EMPTY → `entry_error` pulse, `loadn` stays 1. Key 7 with `timer_running`=1 → ignored, `digit_count` 0, no error. `cancel` after keys 4,2 → digits 0, count 0.
- Keys 2,5, then `start`, then `clear` pulse mid-LOAD → `loadn` rises and digits zero asynchronously, before the next edge.
- `start` and key 8 on the same edge after keys 3,0 → load with 0,0,3,0; no shift, no `entry_error`.
